// File: rtl/div_pkg.sv
// div_pkg: shared width constants and state encoding for the sequential divider
package div_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_ITERS = 16;
  localparam int CNT_W = $clog2(DIV_ITERS);
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
endpackage

// File: rtl/divider_seq_x16_sub.sv
// full_subtractor_x16: 16-bit a - b - cin with borrow out on cout
module full_subtractor_x16
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [DIV_WIDTH-1:0] diff,
  output logic                 cout
);
  logic [DIV_WIDTH:0] full;
  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{DIV_WIDTH{1'b0}}, cin};
    diff = full[DIV_WIDTH-1:0];
    cout = full[DIV_WIDTH];
  end
endmodule

// File: rtl/divider_seq_x16.sv
// divider_seq_x16: 16-bit unsigned restoring divider, one quotient bit per clock
module divider_seq_x16
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);
  div_state_t state_q, state_d;
  logic [DIV_WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic [DIV_WIDTH-1:0] trial, diff;
  logic borrow, accept, go, zero_div;

  full_subtractor_x16 u_sub (.a(trial), .b(d_q), .cin(1'b0), .diff(diff), .cout(borrow));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    go       = start && (state_q != DIV_RUN);
    zero_div = (divisor == '0);
    state_d  = state_q;
    if (go) state_d = zero_div ? DIV_DONE : DIV_RUN;
    else if (state_q == DIV_RUN) state_d = (cnt_q == CNT_W'(DIV_ITERS-1)) ? DIV_DONE : DIV_RUN;
    else state_d = DIV_IDLE;
  end

  // r[15] set means the shifted value is >= 2^16, so it always exceeds d
  always_comb begin
    trial  = {r_q[DIV_WIDTH-2:0], q_q[DIV_WIDTH-1]};
    accept = ~borrow | r_q[DIV_WIDTH-1];
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    dbz_d  = dbz_q;
    if (go) begin
      r_d   = zero_div ? dividend : '0;
      q_d   = zero_div ? '1 : dividend;
      d_d   = divisor;
      cnt_d = '0;
      dbz_d = zero_div;
    end else if (state_q == DIV_RUN) begin
      r_d   = accept ? diff : trial;
      q_d   = {q_q[DIV_WIDTH-2:0], accept};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    busy        = (state_q == DIV_RUN);
    done        = (state_q == DIV_DONE);
    quotient    = q_q;
    remainder   = r_q;
    div_by_zero = dbz_q;
  end
endmodule

// File: doc/divider_seq_x16.md
# divider_seq_x16

Sequential 16-bit unsigned restoring divider for the d16i execution unit. It iterates one quotient bit per clock through a single `full_subtractor_x16` instance, so one subtractor serves all 16 trial subtractions. It uses a start/busy/done handshake toward the ALU issue logic and holds its results until the next accepted start.

## Interface
Parameters: none. Width is fixed at 16 through package constants.

Ports:
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — request a divide. Sampled only when `busy`=0.
- `dividend` in 16 — numerator. Sampled on the accepted start edge only.
- `divisor` in 16 — denominator. Sampled on the accepted start edge only.
- `busy` out 1 — high while iterating (RUN state).
- `done` out 1 — one-cycle pulse; results valid from this cycle onward.
- `quotient` out 16 — result; held until the next accepted start.
- `remainder` out 16 — result; held until the next accepted start.
- `div_by_zero` out 1 — set with `done` when `divisor`=0; held until the next accepted start.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Registers:
  - partial remainder `r[15:0]`
  - shifting dividend/quotient register `q[15:0]`
  - divisor latch `d[15:0]`
  - 4-bit iteration count `cnt`
- Accepted start: `start`=1 while in IDLE or DONE.
  - Divisor ≠ 0: load `r`=0, `q`=`dividend`, `d`=`divisor`, `cnt`=0; go to RUN; clear `div_by_zero`.
  - Divisor = 0: go to DONE directly with `quotient`=0xFFFF, `remainder`=`dividend`, `div_by_zero`=1. No iterations.
- RUN iteration, one per edge:
  - Form `trial = {r[14:0], q[15]}`.
  - Subtractor inputs: a=`trial`, b=`d`, cin=0; gives `diff` and `borrow`.
  - Set `accept = ~borrow | r[15]`. The `r[15]` term covers the case where the shifted value is ≥ 2^16, which always exceeds `d`; in that case `diff`'s low 16 bits are correct.
  - Update: `r` ← `accept` ? `diff` : `trial`; `q` ← `{q[14:0], accept}`; `cnt` ← `cnt`+1.
  - When `cnt`=15, the iteration completes and the state goes to DONE.
- DONE:
  - `quotient`=`q`, `remainder`=`r` (non-zero divisor case).
  - With no start, next state is IDLE.
  - With start, a new operation is accepted (back-to-back).
- `start` while `busy`=1 is ignored. Operand inputs are don't-care outside the accepted start edge.
- Invariant on completion: `dividend` = `quotient`·`divisor` + `remainder`, with `remainder` < `divisor`.

## Timing
- Reset (`rst` high at an edge) forces, from the next cycle:
  - state IDLE
  - `busy`=0, `done`=0
  - `quotient`=0, `remainder`=0, `div_by_zero`=0
  - `cnt`=0
- Reset during RUN aborts the operation; no `done` is produced.
- `rst` takes priority over `start` on the same edge.
- Latency, non-zero divisor:
  - Start accepted at edge E0.
  - `busy`=1 for the 16 cycles following E0.
  - State enters DONE at edge E16; `done` is high in the cycle after E16, i.e. 17 cycles after the start edge.
- Latency, zero divisor: `done` is high in the cycle immediately after E0; `busy` never rises.
- Throughput: one divide per 17 cycles with back-to-back starts issued in DONE.
- The subtractor path is combinational within one cycle. The register-to-register path is 16-bit ripple plus a mux.

## Structure
- Package `div_pkg`:
  - `DIV_WIDTH`=16
  - `DIV_ITERS`=16
  - `typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t`
- One sub-module: `full_subtractor_x16`, instantiated once.
  - `cin` tied to 0.
  - `cout` used as the borrow.
- All control (FSM, counter, shift registers) lives in `divider_seq_x16`; no further hierarchy.

## Test plan
- 100/7: start at E0 → `done` in the cycle after E16; `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` is high exactly 16 cycles.
- 0xFFFF/0x8001 (exercises the `r[15]` path) → `quotient`=1, `remainder`=0x7FFE. Also 0xFFFF/1 → `quotient`=0xFFFF, `remainder`=0.
- 3/10 → `quotient`=0, `remainder`=3. Then 5/0 → `done` in the cycle after the start edge; `quotient`=0xFFFF, `remainder`=5, `div_by_zero`=1; `busy` never high.
- Start 1000/3, then pulse `start` with 9/2 at cycle 5 of RUN → second request ignored; `quotient`=333, `remainder`=1. Next start issued during the DONE cycle with 9/2 → accepted; `quotient`=4, `remainder`=1 after 17 more cycles.
- Start 50/5, assert `rst` at cycle 8 of RUN → next cycle all outputs are 0 and state is IDLE; no `done` pulse. A subsequent start of 50/5 → `quotient`=10, `remainder`=0.
- Random regression, ≥10k operand pairs including divisor=0 → each result matches the software `/` and `%` operators (divisor=0 checked against the defined 0xFFFF / `dividend` result), with the latency exactly as specified.
